// File: rtl/mac_pkg.sv
// Shared definitions for the MAC dot-product datapath: FSM states,
// default widths and saturation-limit helpers.
package mac_pkg;

  localparam int unsigned DEF_WIDTH_INPUT  = 16;
  localparam int unsigned DEF_WIDTH_OUTPUT = 32;
  localparam int unsigned DEF_WIDTH_ACC    = 40;
  localparam int unsigned DEF_WIDTH_LEN    = 16;

  // Helpers return a wide value; callers truncate to their accumulator width.
  localparam int unsigned MAX_ACC_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Largest signed value representable in w bits: 2^(w-1)-1.
  function automatic logic [MAX_ACC_W-1:0] sat_max(input int unsigned w);
    logic [MAX_ACC_W-1:0] one;
    one = 1;
    return (one << (w - 1)) - one;
  endfunction

  // Smallest signed value in w bits; the low w bits are 100..0.
  function automatic logic [MAX_ACC_W-1:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/fixedpoint_multiplier.sv
// Combinational full-precision signed multiplier.
module fixedpoint_multiplier #(
  parameter int unsigned WIDTH_INPUT  = 16,
  parameter int unsigned WIDTH_OUTPUT = 32
) (
  input  logic [WIDTH_INPUT-1:0]  a_i,
  input  logic [WIDTH_INPUT-1:0]  b_i,
  output logic [WIDTH_OUTPUT-1:0] p_o
);

  logic signed [WIDTH_OUTPUT-1:0] a_ext;
  logic signed [WIDTH_OUTPUT-1:0] b_ext;

  // Sign-extend before multiplying so the product is computed at full width.
  assign a_ext = WIDTH_OUTPUT'($signed(a_i));
  assign b_ext = WIDTH_OUTPUT'($signed(b_i));
  assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/dot_product_sequencer.sv
// Length-programmed dot-product sequencer: streams signed operand pairs
// through one fixedpoint_multiplier into a wide signed accumulator.
// Build option: define MAC_SATURATE_EN to clamp the accumulator on signed
// overflow; otherwise it wraps. res_ovf_o is sticky per job either way.
module dot_product_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH_INPUT  = DEF_WIDTH_INPUT,
  parameter int unsigned WIDTH_OUTPUT = DEF_WIDTH_OUTPUT,
  parameter int unsigned WIDTH_ACC    = DEF_WIDTH_ACC,
  parameter int unsigned WIDTH_LEN    = DEF_WIDTH_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [WIDTH_LEN-1:0]   len_i,
  output logic                   busy_o,
  input  logic                   op_valid_i,
  output logic                   op_ready_o,
  input  logic [WIDTH_INPUT-1:0] op_a_i,
  input  logic [WIDTH_INPUT-1:0] op_b_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [WIDTH_ACC-1:0]   res_data_o,
  output logic                   res_ovf_o
);

  state_e                 state_q, state_d;
  logic [WIDTH_LEN-1:0]   cnt_q, cnt_d;
  logic [WIDTH_ACC-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   stage_valid_q, stage_valid_d;
  logic [WIDTH_INPUT-1:0] op_a_q, op_a_d;
  logic [WIDTH_INPUT-1:0] op_b_q, op_b_d;
  logic                   busy_q, busy_d;

  logic [WIDTH_OUTPUT-1:0] prod;
  logic [WIDTH_ACC-1:0]    prod_ext;
  logic [WIDTH_ACC-1:0]    sum;
  logic                    add_ovf;

  fixedpoint_multiplier #(
    .WIDTH_INPUT (WIDTH_INPUT),
    .WIDTH_OUTPUT(WIDTH_OUTPUT)
  ) u_mul (
    .a_i(op_a_q),
    .b_i(op_b_q),
    .p_o(prod)
  );

  // Sign-extend the staged product and detect signed overflow of the add.
  always_comb begin
    prod_ext = WIDTH_ACC'($signed(prod));
    sum      = acc_q + prod_ext;
    add_ovf  = (acc_q[WIDTH_ACC-1] == prod_ext[WIDTH_ACC-1]) &&
               (sum[WIDTH_ACC-1] != acc_q[WIDTH_ACC-1]);
  end

  // Next-state, operand staging and accumulation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    ovf_d         = ovf_q;
    stage_valid_d = 1'b0;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;

    // A staged product always lands one edge after its pair was accepted.
    if (stage_valid_q) begin
      acc_d = sum;
      if (add_ovf) begin
        ovf_d = 1'b1;
`ifdef MAC_SATURATE_EN
        // Both addends share a sign on overflow; clamp toward that sign.
        acc_d = acc_q[WIDTH_ACC-1] ? WIDTH_ACC'(sat_min(WIDTH_ACC))
                                   : WIDTH_ACC'(sat_max(WIDTH_ACC));
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len_i;
          state_d = (len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (op_valid_i) begin
          op_a_d        = op_a_i;
          op_b_d        = op_b_i;
          stage_valid_d = 1'b1;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == WIDTH_LEN'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // State and datapath registers; reset discards any partial job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      ovf_q         <= 1'b0;
      stage_valid_q <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      ovf_q         <= ovf_d;
      stage_valid_q <= stage_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      busy_q        <= busy_d;
    end
  end

  assign op_ready_o  = (state_q == RUN);
  assign res_valid_o = (state_q == DONE);
  assign res_data_o  = acc_q;
  assign res_ovf_o   = ovf_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Scoreboard bench for dot_product_sequencer (32-bit accumulator instance so
// the overflow vectors reach the accumulator limits).
module tb_dot_product_sequencer;

  localparam int WI = 16;
  localparam int WO = 32;
  localparam int WA = 32;
  localparam int WL = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [WL-1:0] len_i = '0;
  logic          busy_o;
  logic          op_valid_i = 1'b0;
  logic          op_ready_o;
  logic [WI-1:0] op_a_i = '0;
  logic [WI-1:0] op_b_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b1;
  logic [WA-1:0] res_data_o;
  logic          res_ovf_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WA-1:0] data;
    logic          ovf;
  } exp_t;
  exp_t sb_q[$];

  dot_product_sequencer #(
    .WIDTH_INPUT (WI),
    .WIDTH_OUTPUT(WO),
    .WIDTH_ACC   (WA),
    .WIDTH_LEN   (WL)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .op_valid_i (op_valid_i),
    .op_ready_o (op_ready_o),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o (res_data_o),
    .res_ovf_o  (res_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every completed result handshake.
  always @(negedge clk_i) begin
    if (rst_ni && res_valid_o && res_ready_i) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_result: got 0x%0h, expected none", res_data_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_data", res_data_o, e.data);
        check("result_ovf", res_ovf_o, e.ovf);
        $display("[TB] result data=0x%08h ovf=%0b (expected 0x%08h ovf=%0b)",
                 res_data_o, res_ovf_o, e.data, e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic [WL-1:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
  endtask

  // Present one pair and hold it until accepted (bounded wait).
  task automatic send(input logic [WI-1:0] a, input logic [WI-1:0] b);
    int n;
    n = 0;
    op_valid_i = 1'b1;
    op_a_i     = a;
    op_b_i     = b;
    while (!op_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("[TB] FAIL op_ready_timeout: got op_ready_o=0, expected 1");
    end
    tick();
    op_valid_i = 1'b0;
  endtask

  task automatic push(input logic [WA-1:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with inputs toggling: outputs must remain zero.
    for (int i = 0; i < 4; i++) begin
      start_i     = i[0];
      len_i       = WL'(i + 1);
      op_valid_i  = ~i[0];
      res_ready_i = i[1];
      op_a_i      = WI'(i * 123);
      @(negedge clk_i);
      check("rst_ready", op_ready_o, 1'b0);
      check("rst_valid", res_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_ovf", res_ovf_o, 1'b0);
      check("rst_data", res_data_o, 32'h0);
    end
    start_i = 0; op_valid_i = 0; res_ready_i = 1; len_i = 0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick();
    check("idle_ready", op_ready_o, 1'b0);
    tick();
    check("idle_ready2", op_ready_o, 1'b0);

    // Basic job: -73 + 6 + 0x4000_0000 = 1073741757.
    push(32'h3FFF_FFBD, 1'b0);
    start_job(16'd3);
    check("run_ready", op_ready_o, 1'b1);
    check("run_busy", busy_o, 1'b1);
    send(16'hFFFF, 16'd73);
    send(16'd2, 16'd3);
    send(16'h8000, 16'h8000);
    check("drain_valid", res_valid_o, 1'b0);
    check("drain_ready", op_ready_o, 1'b0);
    tick();
    check("latency_valid", res_valid_o, 1'b1);
    tick();
    check("basic_idle_busy", busy_o, 1'b0);

    // Overflow: three 0x4000_0000 products into a 32-bit accumulator.
`ifdef MAC_SATURATE_EN
    push(32'h7FFF_FFFF, 1'b1);
`else
    push(32'hC000_0000, 1'b1);
`endif
    start_job(16'd3);
    send(16'h8000, 16'h8000);
    send(16'h8000, 16'h8000);
    send(16'h8000, 16'h8000);
    tick();
    check("ovf_valid", res_valid_o, 1'b1);
    tick();

    // Zero length: result straight away, ovf cleared by the new start.
    push(32'h0, 1'b0);
    start_job(16'd0);
    check("len0_valid", res_valid_o, 1'b1);
    check("len0_data", res_data_o, 32'h0);
    check("len0_busy", busy_o, 1'b1);
    tick();
    check("len0_idle_valid", res_valid_o, 1'b0);
    check("len0_idle_busy", busy_o, 1'b0);

    // Backpressure: gap on operands, consumer stalls, start pulses ignored.
    res_ready_i = 1'b0;
    push(32'hFFFF_FE4B, 1'b0);  // 100*-5 + -7*-9 = -437
    start_job(16'd2);
    send(16'd100, 16'hFFFB);
    repeat (3) tick();
    check("gap_ready", op_ready_o, 1'b1);
    send(16'hFFF9, 16'hFFF7);
    tick();
    check("bp_valid", res_valid_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start_i = 1'b1;
      len_i   = 16'd7;
      tick();
      check("bp_hold_valid", res_valid_o, 1'b1);
      check("bp_hold_data", res_data_o, 32'hFFFF_FE4B);
      check("bp_hold_ovf", res_ovf_o, 1'b0);
    end
    start_i = 1'b0;
    res_ready_i = 1'b1;
    tick();
    check("bp_after_valid", res_valid_o, 1'b0);
    check("bp_after_ready", op_ready_o, 1'b0);
    check("bp_after_busy", busy_o, 1'b0);

    // Reset mid-job after 2 of 4 accepts; partial job produces no result.
    start_job(16'd4);
    send(16'd1000, 16'd1000);
    send(16'd2000, 16'd2000);
    rst_ni = 1'b0;
    #1;
    check("midrst_ready", op_ready_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_valid", res_valid_o, 1'b0);
    check("midrst_ovf", res_ovf_o, 1'b0);
    check("midrst_data", res_data_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("postrst_ready", op_ready_o, 1'b0);
    push(32'h3FFF_0001, 1'b0);
    start_job(16'd1);
    send(16'h7FFF, 16'h7FFF);
    tick();
    check("fresh_valid", res_valid_o, 1'b1);
    tick();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Sequencer that owns one `fixedpoint_multiplier` and drives it through a length-programmed dot product. It accepts a start command with a vector length, then consumes signed operand pairs over a valid/ready stream. Each product is accumulated into a wide signed accumulator, and the final sum is returned over a valid/ready result port. It sits between the operand fetch logic and the downstream result consumer in the MulAdd accumulator datapath.

## Interface
- `WIDTH_INPUT`, 16: signed operand width (two's complement).
- `WIDTH_OUTPUT`, 32: multiplier product width, must equal 2*`WIDTH_INPUT`.
- `WIDTH_ACC`, 40: accumulator/result width, must be ≥ `WIDTH_OUTPUT`.
- `WIDTH_LEN`, 16: length/counter width.
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `start_i` input 1: start command, sampled only in IDLE.
- `len_i` input `WIDTH_LEN`: number of operand pairs, unsigned, sampled with `start_i`.
- `busy_o` output 1: high in every state except IDLE.
- `op_valid_i` input 1: operand pair valid.
- `op_ready_o` output 1: sequencer accepts a pair this cycle.
- `op_a_i`, `op_b_i` input `WIDTH_INPUT` each: signed operands.
- `res_valid_o` output 1: result valid.
- `res_ready_i` input 1: consumer accepts result.
- `res_data_o` output `WIDTH_ACC`: signed dot-product result.
- `res_ovf_o` output 1: sticky accumulator-overflow flag for this job.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- **IDLE**
  - On `start_i`: clear the accumulator, clear ovf, load `len_i` into remaining-count.
  - If `len_i`≠0, go to RUN.
  - If `len_i`=0, go directly to DONE with result 0.
- **RUN**
  - `op_ready_o`=1.
  - Each handshake (`op_valid_i`&`op_ready_o`) registers a,b into the operand stage, sets stage-valid and decrements the count.
  - Handshake with count=1 goes to DRAIN.
  - `op_valid_i` gaps are allowed; the state holds.
- **DRAIN**
  - `op_ready_o`=0.
  - The last staged product enters the accumulator. Go to DONE.
- **DONE**
  - `res_valid_o`=1 with `res_data_o`/`res_ovf_o` stable until `res_ready_i`. Then go to IDLE.
- `start_i` is ignored outside IDLE.
- Arithmetic:
  - The multiplier is combinational on the operand stage: full signed product, e.g. -1×73=-73, 0x8000×0x8000=0x4000_0000.
  - The product is sign-extended to `WIDTH_ACC` and added when stage-valid=1.
  - Overflow is signed overflow of that addition. It sets `res_ovf_o`, which stays set until the next start.
- Reset (any time, including mid-job):
  - All registers clear and the state returns to IDLE.
  - `op_ready_o`, `res_valid_o`, `busy_o`, `res_ovf_o` = 0; `res_data_o` = 0.
  - A partial job is discarded.

## Timing
- Start in IDLE at edge S:
  - `len_i`≠0: RUN from S, so `op_ready_o`=1 in the cycle after S.
  - `len_i`=0: `res_valid_o`=1 in the cycle after S.
- Pair accepted at edge E: its product is in the accumulator after edge E+1.
- Last pair accepted at edge E: DRAIN in cycle E..E+1, and `res_valid_o`=1 from edge E+1. Latency is 2 edges from last accept to result valid.
- Throughput: one pair per cycle in RUN. `op_ready_o` does not depend combinationally on `op_valid_i`.
- Result handshake completing at edge R: IDLE from R. The earliest next start is sampled at R+1.
- `busy_o` is registered.

## Configuration
- `MAC_SATURATE_EN` defined: on overflow the accumulator clamps to the signed max (2^(`WIDTH_ACC`-1)-1) or min (-2^(`WIDTH_ACC`-1)), and later additions continue from the clamped value. `res_ovf_o` is set.
- `MAC_SATURATE_EN` undefined: the accumulator wraps modulo 2^`WIDTH_ACC`. `res_ovf_o` is still set on overflow.

## Structure
- Package `mac_pkg`:
  - FSM state enum (`IDLE`, `RUN`, `DRAIN`, `DONE`).
  - Default width constants.
  - Functions for the saturation limits.
- Sub-module: one instance of the existing `fixedpoint_multiplier` (`WIDTH_INPUT`/`WIDTH_OUTPUT` passed through), driven from the operand stage registers.

## Test plan
- Reset, hold `rst_ni`=0 with inputs toggling: all outputs 0, state IDLE; after release, `op_ready_o`=0 until a start.
- Start, `len_i`=3, pairs (-1,73), (2,3), (0x8000,0x8000) back-to-back: `res_data_o`=1073741757, `res_ovf_o`=0, `res_valid_o` 2 edges after the 3rd accept.
- Start with `len_i`=0: `res_valid_o`=1 the next cycle with `res_data_o`=0; the FSM returns to IDLE on `res_ready_i`.
- Backpressure, `len_i`=2 with a 3-cycle `op_valid_i` gap and `res_ready_i` low for 5 cycles while `start_i` pulses: result stays stable, the start is ignored, and the sum is correct.
- Overflow, `WIDTH_ACC`=32, `len_i`=3, each pair (0x8000,0x8000):
  - With `MAC_SATURATE_EN`: `res_data_o`=0x7FFF_FFFF, `res_ovf_o`=1.
  - Without it: `res_data_o`=0xC000_0000, `res_ovf_o`=1.
- Reset mid-job after 2 of 4 accepts: outputs zero immediately. A new job with `len_i`=1, (0x7FFF,0x7FFF), returns 0x3FFF_0001 with no stale contribution.
